// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: owns the architectural HI/LO pair and sequences the shared
// combinational 32x32 multiplier as a fixed MUL_LAT-cycle multicycle path.
// Optional feature macro: HILO_ZERO_BYPASS_EN (a multiply with a zero operand
// writes HI=LO=0 at acceptance and never occupies the multiplier).
//
// Handshake: an operation is offered with op_valid; it is taken on a clock
// edge only when the sequencer is IDLE and flush is low. While a multiply is
// in flight, stall (busy & (op_valid | rd_req)) acts as the inverse of ready:
// the pipeline must keep presenting the same operation until stall drops, and
// it is then taken on the first IDLE cycle. A flushed offer is discarded.
module hilo_mult_ctrl #(
  parameter int unsigned MUL_LAT = 4  // legal range 1..15 (fits the 4-bit counter)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        rd_req,
  output logic        mul_ena,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        dbg_state
);

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic        r_mul_ena;
  logic        r_mul_sign;
  logic        r_done;

  logic        w_idle;
  logic        w_run;
  logic        w_take;
  logic        w_take_mul;
  logic        w_take_mt;
  logic        w_zero;
  logic        w_bypass;
  logic        w_start_run;
  logic        w_run_end;
  logic        w_wb;

  assign w_idle     = (r_state == S_IDLE);
  assign w_run      = (r_state == S_RUN);
  assign w_take     = w_idle & op_valid & ~flush;
  // op_code[1]=0 selects MULT/MULTU, op_code[1]=1 selects MTHI/MTLO
  assign w_take_mul = w_take & ~op_code[1];
  assign w_take_mt  = w_take &  op_code[1];

`ifdef HILO_ZERO_BYPASS_EN
  assign w_zero = (op_a == 32'd0) | (op_b == 32'd0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_bypass    = w_take_mul & w_zero;
  assign w_start_run = w_take_mul & ~w_zero;
  // RUN ends either by flush (abort) or by the counter reaching zero
  assign w_run_end   = w_run & (flush | (r_cnt == 4'd0));
  // write-back happens only on a natural end; flush wins on the last cycle
  assign w_wb        = w_run & ~flush & (r_cnt == 4'd0);

  // State register and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start_run) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_RUN: begin
        if (w_run_end) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Multiplier operand/enable registers; operands stay frozen during RUN and
  // are retained after a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a    <= 32'd0;
      r_mul_b    <= 32'd0;
      r_mul_sign <= 1'b0;
      r_mul_ena  <= 1'b0;
    end else if (w_start_run) begin
      r_mul_a    <= op_a;
      r_mul_b    <= op_b;
      r_mul_sign <= (op_code == OP_MULT);
      r_mul_ena  <= 1'b1;
    end else if (w_run_end) begin
      r_mul_ena  <= 1'b0;
    end
  end

  // Architectural HI/LO and the one-cycle write-back pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_wb | w_bypass;
      if (w_wb) begin
        r_hi <= mul_hi;
        r_lo <= mul_lo;
      end else if (w_bypass) begin
        r_hi <= 32'd0;
        r_lo <= 32'd0;
      end else if (w_take_mt) begin
        if (op_code[0]) r_lo <= op_a;
        else            r_hi <= op_a;
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_ena   = r_mul_ena;
  assign mul_sign  = r_mul_sign;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign done      = r_done;
  assign busy      = w_run;
  assign stall     = w_run & (op_valid | rd_req);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl. Directed vectors with hand-computed
// products; every multiply write-back is queued as {done cycle, hi, lo} and a
// negedge monitor checks each done pulse against the head of the queue.
module tb_hilo_mult_ctrl;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        rd_req;
  logic        mul_ena;
  logic        mul_sign;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dbg_state;

  logic [31:0] cyc;
  int          n_vec;
  int          n_miss;
  logic [95:0] exp_q[$];

  // external combinational multiplier
  logic [63:0] uprod;
  logic [63:0] sprod;
  assign uprod = {32'd0, mul_a} * {32'd0, mul_b};
  assign sprod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
  assign {mul_hi, mul_lo} = mul_sign ? sprod : uprod;

  hilo_mult_ctrl #(.MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .rd_req(rd_req),
    .mul_ena(mul_ena), .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .hi(hi), .lo(lo), .busy(busy),
    .stall(stall), .done(done), .dbg_state(dbg_state)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expect a done pulse with these HI/LO values at the given cycle count
  task automatic expect_wb(input logic [31:0] at, input logic [31:0] eh, input logic [31:0] el);
    exp_q.push_back({at, eh, el});
  endtask

  // issue a multiply (called at posedge+1) and check the busy window
  task automatic run_mul(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    expect_wb(cyc + 32'd1 + L, eh, el);
    step();
    op_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("mul_ena_run", mul_ena, 1);
      chk("mul_sign_run", mul_sign, (code == 2'd0));
    end
    chk("mul_a_run", mul_a, a);
    chk("mul_b_run", mul_b, b);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("mul_ena_after", mul_ena, 0);
    chk("hi_after", hi, eh);
    chk("lo_after", lo, el);
    step();
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    op_valid = 1'b1; op_code = 2'd2; op_a = h;
    step();
    op_code = 2'd3; op_a = l;
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_q_empty();
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL wb_timeout: got %0d pending write-backs, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor: every done pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL done_unexpected: got done=1 at cyc %0d, required 0", cyc);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          if (cyc !== e[95:64] || hi !== e[63:32] || lo !== e[31:0]) begin
            n_miss++;
            $display("FAIL done_wb: got cyc %0d hi %h lo %h, required cyc %0d hi %h lo %h",
                     cyc, hi, lo, e[95:64], e[63:32], e[31:0]);
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0][95:64]) begin
        n_vec++;
        n_miss++;
        $display("FAIL done_missing: got no done by cyc %0d, required at cyc %0d", cyc, exp_q[0][95:64]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; op_valid = 1'b0; op_code = 2'd0; op_a = 32'd0; op_b = 32'd0;
    flush = 1'b0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_ena", mul_ena, 0);
    chk("rst_mul_sign", mul_sign, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_state", dbg_state, 0);
    step();

    // signed and unsigned multiplies
    run_mul(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mul(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    run_mul(2'd1, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 32'h0000_0000);

    // MTHI/MTLO, then an MFHI the following cycle sees no stall
    write_hilo(32'h0000_AAAA, 32'h0000_5555);
    rd_req = 1'b1;
    @(negedge clk);
    chk("mt_hi", hi, 32'h0000_AAAA);
    chk("mt_lo", lo, 32'h0000_5555);
    chk("mt_stall", stall, 0);
    chk("mt_done", done, 0);
    step();
    rd_req = 1'b0;

    // flush on RUN cycle 2: no write-back, operands retained
    op_valid = 1'b1; op_code = 2'd0; op_a = 32'd3; op_b = 32'd5;
    step();
    op_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl2_busy", busy, 0);
    chk("fl2_mul_ena", mul_ena, 0);
    chk("fl2_mul_a", mul_a, 32'd3);
    chk("fl2_mul_b", mul_b, 32'd5);
    repeat (L + 2) @(negedge clk);
    chk("fl2_hi", hi, 32'h0000_AAAA);
    chk("fl2_lo", lo, 32'h0000_5555);
    step();

    // flush on the last RUN cycle
    op_valid = 1'b1; op_code = 2'd1; op_a = 32'd6; op_b = 32'd7;
    step();
    op_valid = 1'b0;
    repeat (L - 1) step();
    flush = 1'b1;
    @(negedge clk);
    chk("fll_busy_last", busy, 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fll_busy", busy, 0);
    chk("fll_hi", hi, 32'h0000_AAAA);
    chk("fll_lo", lo, 32'h0000_5555);
    chk("fll_mul_a", mul_a, 32'd6);
    step();

    // flush in IDLE drops a simultaneous multiply and a simultaneous MTHI
    op_valid = 1'b1; op_code = 2'd0; op_a = 32'd9; op_b = 32'd9; flush = 1'b1;
    step();
    op_code = 2'd2; op_a = 32'h0000_BEEF;
    step();
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fli_busy", busy, 0);
    chk("fli_mul_ena", mul_ena, 0);
    chk("fli_mul_a", mul_a, 32'd6);
    chk("fli_hi", hi, 32'h0000_AAAA);
    step();

    // hazard: MTLO and an MFHI wait behind an in-flight MULT
    op_valid = 1'b1; op_code = 2'd0; op_a = 32'h7FFF_FFFF; op_b = 32'h7FFF_FFFF;
    expect_wb(cyc + 32'd1 + L, 32'h3FFF_FFFF, 32'h0000_0001);
    step();
    op_code = 2'd3; op_a = 32'h0000_1234; rd_req = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk("hz_stall", stall, 1);
      chk("hz_lo_hold", lo, 32'h0000_5555);
    end
    @(negedge clk);
    chk("hz_stall_end", stall, 0);
    chk("hz_busy_end", busy, 0);
    step();
    op_valid = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk("hz_hi", hi, 32'h3FFF_FFFF);
    chk("hz_lo", lo, 32'h0000_1234);
    step();

    // back-to-back: second multiply held and taken on the edge after write-back
    op_valid = 1'b1; op_code = 2'd1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    expect_wb(cyc + 32'd1 + L, 32'hFFFF_FFFE, 32'h0000_0001);
    expect_wb(cyc + 32'd2 + 2 * L, 32'h0000_0000, 32'h0000_0001);
    step();
    op_code = 2'd0;
    repeat (L) step();
    step();
    op_valid = 1'b0;
    wait_q_empty();
    @(negedge clk);
    chk("b2b_hi", hi, 32'h0000_0000);
    chk("b2b_lo", lo, 32'h0000_0001);
    step();

    // zero operand
    write_hilo(32'h0000_1111, 32'h0000_2222);
`ifdef HILO_ZERO_BYPASS_EN
    op_valid = 1'b1; op_code = 2'd0; op_a = 32'd0; op_b = 32'd7;
    expect_wb(cyc + 32'd1, 32'd0, 32'd0);
    step();
    op_valid = 1'b0;
    @(negedge clk);
    chk("zb_hi", hi, 0);
    chk("zb_lo", lo, 0);
    chk("zb_busy", busy, 0);
    chk("zb_mul_ena", mul_ena, 0);
    step();
`else
    run_mul(2'd0, 32'd0, 32'd7, 32'd0, 32'd0);
`endif
    wait_q_empty();

    // asynchronous reset in the middle of RUN
    step();
    write_hilo(32'h0000_AAAA, 32'h0000_5555);
    op_valid = 1'b1; op_code = 2'd0; op_a = 32'd5; op_b = 32'd5;
    step();
    op_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_hi", hi, 0);
    chk("ar_lo", lo, 0);
    chk("ar_busy", busy, 0);
    chk("ar_mul_ena", mul_ena, 0);
    chk("ar_mul_a", mul_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 2) @(negedge clk);
    chk("ar_busy_late", busy, 0);
    chk("ar_hi_late", hi, 0);

    wait_q_empty();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
